// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: instruction-memory request/response, decode-side FIFO head
// and execute-stage redirect.
interface fetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  imem_req_valid;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [31:0]           imem_rsp_instr;
  logic                  de_valid;
  logic [ADDR_WIDTH-1:0] de_pc;
  logic [31:0]           de_instruction;
  logic [ADDR_WIDTH-1:0] de_pc_plus_4;
  logic                  de_ready;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_address;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_instr,
    output de_valid, de_pc, de_instruction, de_pc_plus_4,
    input  de_ready, redirect, redirect_address
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_instr,
    input  de_valid, de_pc, de_instruction, de_pc_plus_4,
    output de_ready, redirect, redirect_address
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC owner, in-order imem requests, {pc, instr, pc+4} FIFO.
// Optional FETCH_QUEUE_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_queue #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] initial_address,
   fetch_queue_if.master         bus
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0]           perf_fetched,
   output logic [31:0]           perf_stall
`endif
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

   typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CntW-1:0]       inflight_q, inflight_d, count_q, count_d;
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q, tag_wr_q, tag_rd_q;
   logic [ADDR_WIDTH-1:0] fifo_pc    [DEPTH];
   logic [31:0]           fifo_instr [DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_pp4   [DEPTH];
   logic [ADDR_WIDTH-1:0] tag_pc     [DEPTH];

   logic                  accept, rsp, push, pop, flush_fifo;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  unused_low_bits;

   assign redirect_pc     = {bus.redirect_address[ADDR_WIDTH-1:2], 2'b00};
   assign unused_low_bits = ^{initial_address[1:0], bus.redirect_address[1:0]};

   assign bus.imem_req_addr  = pc_q;
   assign bus.de_valid       = (count_q != '0);
   assign bus.de_pc          = fifo_pc[rd_ptr_q];
   assign bus.de_instruction = fifo_instr[rd_ptr_q];
   assign bus.de_pc_plus_4   = fifo_pp4[rd_ptr_q];

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      flush_fifo = 1'b0;
      // Credit rule: buffered + outstanding never exceeds DEPTH, so a response always fits.
      bus.imem_req_valid = (state_q == StRun) &&
                           (({1'b0, count_q} + {1'b0, inflight_q}) < DepthC);
      accept     = bus.imem_req_valid && bus.imem_req_ready;
      rsp        = bus.imem_rsp_valid && (state_q != StBoot);
      inflight_d = inflight_q + CntW'(accept) - CntW'(rsp);

      unique case (state_q)
         StBoot: begin
            pc_d    = {initial_address[ADDR_WIDTH-1:2], 2'b00};
            state_d = StRun;
         end
         StRun: begin
            if (bus.redirect) begin
               pc_d       = redirect_pc;
               flush_fifo = 1'b1;
               if (inflight_d != '0) state_d = StFlush;
            end else if (accept) begin
               pc_d = pc_q + ADDR_WIDTH'(4);
            end
         end
         StFlush: begin
            if (bus.redirect) pc_d = redirect_pc;
            if (inflight_q == '0) state_d = StRun;
         end
         default: state_d = StBoot;
      endcase

      push    = (state_q == StRun) && bus.imem_rsp_valid && !bus.redirect;
      pop     = bus.de_valid && bus.de_ready;
      count_d = flush_fifo ? '0 : count_q + CntW'(push) - CntW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StBoot;
         pc_q       <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= '0;
            fifo_pp4[i]   <= '0;
            tag_pc[i]     <= '0;
         end
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         // Tag queue tracks every outstanding request, including ones later discarded.
         if (accept) begin
            tag_pc[tag_wr_q] <= pc_q;
            tag_wr_q         <= tag_wr_q + 1'b1;
         end
         if (rsp) tag_rd_q <= tag_rd_q + 1'b1;
         if (push) begin
            fifo_pc[wr_ptr_q]    <= tag_pc[tag_rd_q];
            fifo_instr[wr_ptr_q] <= bus.imem_rsp_instr;
            fifo_pp4[wr_ptr_q]   <= tag_pc[tag_rd_q] + ADDR_WIDTH'(4);
            wr_ptr_q             <= wr_ptr_q + 1'b1;
         end
         if (flush_fifo) rd_ptr_q <= wr_ptr_q;
         else if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop) perf_fetched <= perf_fetched + 32'd1;
         if (!bus.de_valid && (state_q != StBoot)) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
